// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and FSM encoding for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after ptr, wrapping.
// Returns a one-hot grant, its index and whether anything was picked.
module rr_pick #(
   parameter int unsigned N     = 3,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int unsigned cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= N) cand = cand - N;
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte producers with round-robin
// arbitration, packet locking and an idle gap after every byte.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ      = 3,
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [BYTE_W*N_REQ-1:0]   req_bits,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      tx_valid,
   output logic [BYTE_W-1:0]         tx_bits,
   input  logic                      tx_ready,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      locked,
   output logic [CNT_W-1:0]          sent_count
);

   localparam int unsigned IDX_W = $clog2(N_REQ);
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [IDX_W-1:0]  rr_ptr;
   logic              last_flag;
   logic [GAP_W-1:0]  gap_cnt;

   logic [N_REQ-1:0]  owner_mask;
   logic [N_REQ-1:0]  eligible;
   logic [N_REQ-1:0]  pick_grant;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;
   logic [BYTE_W-1:0] sel_bits;
   logic              sel_last;
   logic              accept;
   logic              tx_fire;

   // While a packet is open only its owner may compete.
   assign owner_mask = N_REQ'(1) << grant_id;
   assign eligible   = locked ? (req_valid & owner_mask) : req_valid;

   rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
      .req   (eligible),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      sel_bits = '0;
      sel_last = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (pick_grant[i]) begin
            sel_bits = req_bits[i*BYTE_W +: BYTE_W];
            sel_last = req_last[i];
         end
      end
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (accept)  state_nxt = ST_SEND;
         ST_SEND: if (tx_fire) state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
         ST_GAP:  if (gap_cnt == '0) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output / handshake decode
   always_comb begin
      req_ready = '0;
      accept    = 1'b0;
      if (state == ST_IDLE) begin
         req_ready = pick_grant;
         accept    = pick_any;
      end
      tx_fire = tx_valid & tx_ready;
   end

   // Datapath: latched byte, ownership, pointer, counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_valid   <= 1'b0;
         tx_bits    <= '0;
         last_flag  <= 1'b0;
         grant_id   <= '0;
         rr_ptr     <= IDX_W'(N_REQ - 1);
         locked     <= 1'b0;
         sent_count <= '0;
         gap_cnt    <= '0;
      end else begin
         if (accept) begin
            tx_valid  <= 1'b1;
            tx_bits   <= sel_bits;
            last_flag <= sel_last;
            grant_id  <= pick_idx;
            rr_ptr    <= pick_idx;
         end else if (tx_fire) begin
            tx_valid <= 1'b0;
         end
         if (tx_fire) begin
            sent_count <= sent_count + CNT_W'(1);
            locked     <= ~last_flag;
            gap_cnt    <= GAP_LOAD;
         end else if (state == ST_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UARTTransmitter among N_REQ byte producers, e.g. manual-command encoder, script executor and heartbeat/echo.
- Uses round-robin arbitration with packet locking: once a requester wins, it keeps the transmitter until it sends a byte flagged last.
- Inserts a configurable idle gap between bytes so the PC-side client can frame them.
- Sits between the command logic and UARTTransmitter; drives its io_valid/io_bits and watches its io_ready.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- GAP_CYCLES, 16, idle clock cycles after each accepted byte before the next arbitration (0 = none).
- CNT_W, 16, width of the sent-byte counter.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-requester byte available
- req_bits  input  8*N_REQ  byte of requester i at [8*i+7:8*i]
- req_last  input  N_REQ  byte of requester i ends its packet
- req_ready  output  N_REQ  one-hot accept; a byte transfers when req_valid[i] & req_ready[i]
- tx_valid  output  1  to UARTTransmitter io_valid
- tx_bits  output  8  to UARTTransmitter io_bits
- tx_ready  input  1  from UARTTransmitter io_ready
- grant_id  output  $clog2(N_REQ)  current or last owner
- locked  output  1  a packet is in progress
- sent_count  output  CNT_W  bytes handed to the transmitter; wraps

Behaviour:
- Reset values: req_ready=0, tx_valid=0, tx_bits=0, grant_id=0, locked=0, sent_count=0, state=IDLE, rr_ptr=N_REQ-1 (requester 0 wins first).
- FSM states are IDLE, SEND and GAP.
- IDLE, unlocked: winner is the first i with req_valid[i], scanning rr_ptr+1, rr_ptr+2, … modulo N_REQ.
  - req_ready is combinational one-hot of the winner, asserted only in IDLE. No valid → req_ready=0.
  - On transfer: latch tx_bits and last_flag, set grant_id=winner, rr_ptr=winner, go SEND.
- IDLE, locked: only requester grant_id is eligible; the others see req_ready=0 even if valid. Wait indefinitely for it.
- SEND: tx_valid=1 and tx_bits holds the latched value. Wait for tx_ready.
  - On tx_valid & tx_ready: sent_count+1 (wraps at 2^CNT_W); locked <= ~last_flag.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
  - tx_valid drops the cycle after the handshake.
- GAP: down-counter loaded with GAP_CYCLES-1 on entry; go to IDLE when it reaches 0. GAP lasts exactly GAP_CYCLES cycles; req_ready=0 throughout.
- Latency: requester accept → tx_valid high on the next cycle. If tx_ready is already 1, the handshake occurs in that cycle.
- A latched byte is committed: deasserting req_valid after transfer has no effect.
- A single-byte packet is req_last=1 on its only byte; rotation resumes immediately after its gap.
- tx_bits is stable while tx_valid=1 and tx_ready=0 (Decoupled rule).
- Reset mid-SEND or mid-GAP: the byte is dropped and lock is cleared. tx_valid=0 from the cycle after reset is sampled; all reset values apply.
- Simultaneous valids are resolved only by the rotating pointer; no fixed priority except straight after reset.
- Requester indices with req_valid=0 are skipped with no cycle penalty.

Decomposition:
- Shared package holds the byte width constant (8) and FSM state encoding (IDLE/SEND/GAP).
- A natural sub-module is rr_pick: combinational round-robin priority selector taking req mask and rr_ptr, returning a one-hot grant plus an index. It is reusable for the receive-side dispatcher.

Test Plan:
- Single requester: after reset, req0 sends 0x65 with last=1 and tx_ready=1.
  - req_ready[0] pulses once and tx_valid=1 with tx_bits=0x65 next cycle.
  - sent_count=1; next accept is no earlier than 16 cycles later.
- Contention: req0/1/2 all valid, every byte last=1, tx_ready=1.
  - Grants are 0,1,2,0 in order; grant_id follows.
- Packet lock: req1 sends 0x21 (last=0) while req0 is valid.
  - req0 gets no req_ready until req1 sends 0x22 with last=1.
  - Transmitted order is 0x21, 0x22, then req0's byte.
- Transmitter backpressure: tx_ready=0 for 40 cycles during SEND.
  - tx_valid and tx_bits are held constant and sent_count is unchanged.
  - Exactly one handshake occurs when tx_ready rises.
- Reset mid-operation: assert reset in SEND with locked=1.
  - Next cycle tx_valid=0, locked=0, sent_count=0.
  - First post-reset contention of req1 and req2 grants req1.
- Counter wrap with CNT_W=4: send 17 bytes → sent_count=1.
